// File: rtl/alu_core.sv
// alu_core
//   64-bit integer ALU for the execute stage of a single-cycle LEGv8 datapath.
//   The result and zero outputs are purely combinational from a, b and
//   ALUControl. A 4-bit NZCV flag register loads the flags of the current
//   operation on the rising clock edge when flag_we is high.
//
// Ports
//   clk         in   1   system clock; the NZCV register updates on the rising edge
//   reset       in   1   asynchronous, active-high; clears the flag register
//   a           in   N   operand A (Rn)
//   b           in   N   operand B (Rm or an already extended immediate)
//   ALUControl  in   4   operation select
//   flag_we     in   1   1 = load NZCV from the current operation at the next posedge
//   result      out  N   operation result (combinational)
//   zero        out  1   1 when result == 0 (combinational)
//   flags       out  4   registered {N,Z,C,V}
module alu_core #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  input  logic         flag_we,
  output logic [N-1:0] result,
  output logic         zero,
  output logic [3:0]   flags
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;

  logic         is_sub;
  logic [N-1:0] add_b;
  logic [N:0]   sum_ext;
  logic         n_flag;
  logic         z_flag;
  logic         c_flag;
  logic         v_flag;
  logic [3:0]   flags_d;
  logic [3:0]   flags_q;

  // ADD and SUB share one adder: subtraction is a + ~b + 1, so the carry
  // out of the extended sum is the "no borrow" flag directly.
  always_comb begin
    is_sub  = (ALUControl == OP_SUB);
    add_b   = is_sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, add_b} + {{N{1'b0}}, is_sub};
  end

  // Result select; unused codes drive zero so nothing undefined escapes.
  always_comb begin
    result = '0;
    case (ALUControl)
      OP_AND:   result = a & b;
      OP_ORR:   result = a | b;
      OP_ADD:   result = sum_ext[N-1:0];
      OP_SUB:   result = sum_ext[N-1:0];
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
    zero = (result == '0);
  end

  // Next NZCV values; C and V are only meaningful for the arithmetic ops.
  always_comb begin
    n_flag = result[N-1];
    z_flag = zero;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        c_flag = sum_ext[N];
        v_flag = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      OP_SUB: begin
        c_flag = sum_ext[N];
        v_flag = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      default: begin
        c_flag = 1'b0;
        v_flag = 1'b0;
      end
    endcase
    flags_d = flag_we ? {n_flag, z_flag, c_flag, v_flag} : flags_q;
  end

  // Flag register; reset clears it immediately, independent of the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core
//   Directed-vector bench for alu_core. Each vector pushes its hand-computed
//   expected result/zero/flags into a queue; a monitor process pops and
//   compares whenever a sample strobe is raised mid-cycle.
module tb_alu_core;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   ALUControl;
  logic         flag_we;
  logic [N-1:0] result;
  logic         zero;
  logic [3:0]   flags;

  typedef struct {
    logic [N-1:0] res;
    logic         zro;
    logic [3:0]   flg;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  alu_core #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .flag_we    (flag_we),
    .result     (result),
    .zero       (zero),
    .flags      (flags)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation per strobe and compares all three outputs.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL scoreboard_empty: strobe with no expected entry");
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("[TB] FAIL %s.result: got %0d (0x%h) want %0d (0x%h)",
                   e.name, $signed(result), result, $signed(e.res), e.res);
        end
        checks++;
        if (zero !== e.zro) begin
          errors++;
          $display("[TB] FAIL %s.zero: got %b want %b", e.name, zero, e.zro);
        end
        checks++;
        if (flags !== e.flg) begin
          errors++;
          $display("[TB] FAIL %s.flags: got %b want %b", e.name, flags, e.flg);
        end
      end
    end
  end

  // Push the expectation and strobe the monitor at the current time.
  task automatic checkOutput(input string name, input longint exp_res,
                             input logic exp_zero, input logic [3:0] exp_flags);
    exp_t e;
    e.res  = exp_res;
    e.zro  = exp_zero;
    e.flg  = exp_flags;
    e.name = name;
    exp_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  // Drive one vector just after a rising edge; check it on the falling edge,
  // where flags still show what was latched at earlier edges.
  task automatic applyStimulus(input string name, input longint a_in, input longint b_in,
                               input logic [3:0] op, input logic we, input longint exp_res,
                               input logic exp_zero, input logic [3:0] exp_flags);
    @(posedge clk);
    #1;
    a          = a_in;
    b          = b_in;
    ALUControl = op;
    flag_we    = we;
    @(negedge clk);
    checkOutput(name, exp_res, exp_zero, exp_flags);
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    a          = '0;
    b          = '0;
    ALUControl = 4'b0000;
    flag_we    = 1'b0;
    #12;
    checkOutput("reset_state", 0, 1'b1, 4'b0000);
    #5;
    reset = 1'b0;

    // Zero operands on every defined opcode
    applyStimulus("zero_and",   0, 0, 4'b0000, 1'b0, 0, 1'b1, 4'b0000);
    applyStimulus("zero_orr",   0, 0, 4'b0001, 1'b0, 0, 1'b1, 4'b0000);
    applyStimulus("zero_add",   0, 0, 4'b0010, 1'b0, 0, 1'b1, 4'b0000);
    applyStimulus("zero_sub",   0, 0, 4'b0110, 1'b0, 0, 1'b1, 4'b0000);
    applyStimulus("zero_passb", 0, 0, 4'b0111, 1'b0, 0, 1'b1, 4'b0000);

    // Small positive operands
    applyStimulus("pos_and",   239, 26, 4'b0000, 1'b0, 10,  1'b0, 4'b0000);
    applyStimulus("pos_orr",   239, 26, 4'b0001, 1'b0, 255, 1'b0, 4'b0000);
    applyStimulus("pos_add",   239, 26, 4'b0010, 1'b0, 265, 1'b0, 4'b0000);
    applyStimulus("pos_sub",   239, 26, 4'b0110, 1'b0, 213, 1'b0, 4'b0000);
    applyStimulus("pos_passb", 239, 26, 4'b0111, 1'b0, 26,  1'b0, 4'b0000);

    // Negative operands
    applyStimulus("neg_and",   -98, -407, 4'b0000, 1'b0, -504, 1'b0, 4'b0000);
    applyStimulus("neg_orr",   -98, -407, 4'b0001, 1'b0, -1,   1'b0, 4'b0000);
    applyStimulus("neg_add",   -98, -407, 4'b0010, 1'b0, -505, 1'b0, 4'b0000);
    applyStimulus("neg_sub",   -98, -407, 4'b0110, 1'b0, 309,  1'b0, 4'b0000);
    applyStimulus("neg_passb", -98, -407, 4'b0111, 1'b0, -407, 1'b0, 4'b0000);
    applyStimulus("mix_and",   930, -33,  4'b0000, 1'b0, 898,  1'b0, 4'b0000);
    applyStimulus("mix_add",   930, -33,  4'b0010, 1'b0, 897,  1'b0, 4'b0000);
    applyStimulus("mix_sub",   930, -33,  4'b0110, 1'b0, 963,  1'b0, 4'b0000);

    // Zero-result boundaries
    applyStimulus("sub_from_zero", 0,   -635, 4'b0110, 1'b0, 635, 1'b0, 4'b0000);
    applyStimulus("and_to_zero",   593, 0,    4'b0000, 1'b0, 0,   1'b1, 4'b0000);
    applyStimulus("passb_zero",    593, 0,    4'b0111, 1'b0, 0,   1'b1, 4'b0000);

    // Flag register: signed overflow on ADD, then equal SUB, then hold
    applyStimulus("flag_add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1, 4'b0010, 1'b1,
                  64'h8000_0000_0000_0000, 1'b0, 4'b0000);
    applyStimulus("flag_sub_eq",  5,   5,  4'b0110, 1'b1, 0,   1'b1, 4'b1001);
    applyStimulus("flag_hold1",   239, 26, 4'b0001, 1'b0, 255, 1'b0, 4'b0110);
    applyStimulus("flag_hold2",   239, 26, 4'b0000, 1'b0, 10,  1'b0, 4'b0110);

    // Asynchronous reset between edges clears flags but not the result
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 10, 1'b0, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Undefined opcode: result 0, zero 1, and its flags (Z only) can be loaded
    applyStimulus("undef_op",      -98, -407, 4'b1111, 1'b1, 0,   1'b1, 4'b0000);
    applyStimulus("undef_flags",   -98, -407, 4'b0011, 1'b0, 0,   1'b1, 4'b0100);
    applyStimulus("sub_borrow",    3,   5,    4'b0110, 1'b1, -2,  1'b0, 4'b0100);
    applyStimulus("sub_borrow_fl", 3,   5,    4'b0110, 1'b0, -2,  1'b0, 4'b1000);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
